// File: rtl/stopwatch_button_controller.sv
// Stopwatch button front end: two raw push-buttons are synchronized,
// debounced and edge-detected, then drive a small IDLE/RUNNING/PAUSED
// state machine. That machine produces the run-enable level and the
// one-cycle clear pulse for the downstream stopwatch counter.
// Button index 0 is start/stop and index 1 is clear.
module stopwatch_button_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_100_Mhz,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       start,
  output logic       sw_reset,
  output logic [1:0] state,
  output logic       running_led,
  output logic       paused_led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    INVALID = 2'b11
  } state_t;

  logic [1:0]       w_btnRaw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_stable;
  logic [1:0]       r_stableDly;
  logic [1:0]       r_press;
  logic [CNT_W-1:0] r_cnt [2];

  logic             w_startPress;
  logic             w_clearPress;
  state_t           r_state;
  state_t           w_stateNext;
  logic             w_swResetNext;

  assign w_btnRaw     = {btn_clear, btn_start_stop};
  assign w_startPress = r_press[0];
  assign w_clearPress = r_press[1];
  assign state        = r_state;

  // Two-flop synchronizer bringing both asynchronous buttons into the clock domain.
  always_ff @(posedge clk_100_Mhz) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btnRaw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: the stable level only follows the input after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk_100_Mhz) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge detector turning each debounced press into a single-cycle pulse.
  always_ff @(posedge clk_100_Mhz) begin
    if (reset) begin
      r_stableDly <= '0;
      r_press     <= '0;
    end else begin
      r_stableDly <= r_stable;
      r_press     <= r_stable & ~r_stableDly;
    end
  end

  // State register with all outputs registered from the next state so they change together.
  always_ff @(posedge clk_100_Mhz) begin
    if (reset) begin
      r_state     <= IDLE;
      start       <= 1'b0;
      sw_reset    <= 1'b0;
      running_led <= 1'b0;
      paused_led  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      start       <= (w_stateNext == RUNNING);
      sw_reset    <= w_swResetNext;
      running_led <= (w_stateNext == RUNNING);
      paused_led  <= (w_stateNext == PAUSED);
    end
  end

  // Next-state logic: start toggles run/pause, clear is honoured only when not running, clear wins outside RUNNING.
  always_comb begin
    w_stateNext   = r_state;
    w_swResetNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_clearPress) begin
          w_swResetNext = 1'b1;
        end else if (w_startPress) begin
          w_stateNext = RUNNING;
        end
      end
      RUNNING: begin
        if (w_startPress) begin
          w_stateNext = PAUSED;
        end
      end
      PAUSED: begin
        if (w_clearPress) begin
          w_stateNext   = IDLE;
          w_swResetNext = 1'b1;
        end else if (w_startPress) begin
          w_stateNext = RUNNING;
        end
      end
      INVALID: begin
        w_stateNext   = IDLE;
        w_swResetNext = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_stopwatch_button_controller.sv
// Bench for stopwatch_button_controller with a short debounce window.
// The reference model keeps the per-cycle history of the raw buttons and
// derives the debounced level from a sliding window over that history,
// then applies the stopwatch button rules to the resulting press events.
module tb_stopwatch_button_controller;

  localparam int D    = 4;
  localparam int MAXN = 4096;

  logic       clk_100_Mhz = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       start;
  logic       sw_reset;
  logic [1:0] state;
  logic       running_led;
  logic       paused_led;

  int total = 0;
  int bad   = 0;

  // Reference model history, indexed by clock edge since the last reset release.
  bit         mRaw    [2][MAXN];
  bit         mStable [2][MAXN];
  bit         mPress  [2][MAXN];
  logic [1:0] mState  [MAXN];
  bit         mSw     [MAXN];
  int         mN = 0;

  stopwatch_button_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_100_Mhz   (clk_100_Mhz),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .start         (start),
    .sw_reset      (sw_reset),
    .state         (state),
    .running_led   (running_led),
    .paused_led    (paused_led)
  );

  // 100 MHz clock.
  always #5 clk_100_Mhz = ~clk_100_Mhz;

  function automatic bit rawAt(int b, int i);
    if (i < 0) return 1'b0;
    return mRaw[b][i];
  endfunction

  function automatic bit stableAt(int b, int i);
    if (i < 0) return 1'b0;
    return mStable[b][i];
  endfunction

  function automatic bit pressAt(int b, int i);
    if (i < 0) return 1'b0;
    return mPress[b][i];
  endfunction

  function automatic logic [1:0] stateAt(int i);
    if (i < 0) return 2'b00;
    return mState[i];
  endfunction

  function automatic bit swAt(int i);
    if (i < 0) return 1'b0;
    return mSw[i];
  endfunction

  function automatic logic [5:0] obsVec();
    return {state, start, sw_reset, running_led, paused_led};
  endfunction

  function automatic logic [5:0] expVec();
    logic [1:0] s;
    s = stateAt(mN - 1);
    return {s, (s == 2'b01), swAt(mN - 1), (s == 2'b01), (s == 2'b10)};
  endfunction

  // The debounced level flips once the last D samples seen past the
  // two-cycle synchronizer all disagree with it; a press is a 0->1 of that
  // level, and the outputs react one edge after the press.
  task automatic modelStep(input bit s, input bit c);
    bit         prev;
    bit         allDiff;
    logic [1:0] ps;
    logic [1:0] ns;
    bit         sw;
    if (mN >= MAXN) begin
      bad++;
      $display("[TB] FAIL model_overflow: got index %0d required below %0d", mN, MAXN);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] model history exhausted");
    end
    mRaw[0][mN] = s;
    mRaw[1][mN] = c;
    for (int b = 0; b < 2; b++) begin
      prev    = stableAt(b, mN - 1);
      allDiff = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (rawAt(b, mN - 2 - j) == prev) allDiff = 1'b0;
      end
      mStable[b][mN] = allDiff ? ~prev : prev;
      mPress[b][mN]  = stableAt(b, mN - 1) & ~stableAt(b, mN - 2);
    end
    ps = stateAt(mN - 1);
    ns = ps;
    sw = 1'b0;
    if (ps == 2'b01) begin
      if (pressAt(0, mN - 1)) ns = 2'b10;
    end else if (pressAt(1, mN - 1)) begin
      ns = 2'b00;
      sw = 1'b1;
    end else if (pressAt(0, mN - 1)) begin
      ns = 2'b01;
    end
    mState[mN] = ns;
    mSw[mN]    = sw;
    mN++;
  endtask

  task automatic applyStimulus(input bit s, input bit c);
    @(negedge clk_100_Mhz);
    reset          = 1'b0;
    btn_start_stop = s;
    btn_clear      = c;
    @(posedge clk_100_Mhz);
    modelStep(s, c);
    #1;
  endtask

  task automatic holdReset(input int cycles, input bit s, input bit c);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_100_Mhz);
      reset          = 1'b1;
      btn_start_stop = s;
      btn_clear      = c;
      @(posedge clk_100_Mhz);
      #1;
    end
    mN = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_100_Mhz);
      reset          = 1'b1;
      btn_start_stop = 1'($urandom_range(0, 1));
      btn_clear      = 1'($urandom_range(0, 1));
      @(posedge clk_100_Mhz);
      #1;
      total++;
      if (obsVec() !== 6'b0) begin
        bad++;
        $display("[TB] FAIL reset_outputs: got %b required %b", obsVec(), 6'b0);
      end
    end
    mN = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0);
      total++;
      if (obsVec() !== expVec() || obsVec() !== 6'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_single_press();
    holdReset(2, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL single_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
      if (k == 7) begin
        total++;
        if ({state, start} !== 3'b000) begin
          bad++;
          $display("[TB] FAIL single_early: got %b required %b", {state, start}, 3'b000);
        end
      end
      if (k >= 8) begin
        total++;
        if ({state, start, running_led} !== 4'b0111) begin
          bad++;
          $display("[TB] FAIL single_run step %0d: got %b required %b", k, {state, start, running_led}, 4'b0111);
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0);
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL single_release step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
  endtask

  task automatic test_double_press();
    logic [1:0] afterFirst;
    holdReset(2, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(k < 20, 1'b0);
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL double_model1 step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
    afterFirst = state;
    total++;
    if ({afterFirst, start} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL double_first: got %b required %b", {afterFirst, start}, 3'b011);
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL double_model2 step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
    total++;
    if ({state, start, paused_led} !== 4'b1001) begin
      bad++;
      $display("[TB] FAIL double_paused: got %b required %b", {state, start, paused_led}, 4'b1001);
    end
  endtask

  task automatic test_bounce();
    bit         pat [6];
    int         changes;
    logic [1:0] prevState;
    bit         s;
    pat       = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    changes   = 0;
    holdReset(2, 1'b0, 1'b0);
    prevState = state;
    for (int k = 1; k <= 26; k++) begin
      s = (k <= 6) ? pat[k-1] : 1'b1;
      applyStimulus(s, 1'b0);
      if (state !== prevState) changes++;
      prevState = state;
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL bounce_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
      if (k == 12 || k == 13) begin
        total++;
        if (state !== ((k == 13) ? 2'b01 : 2'b00)) begin
          bad++;
          $display("[TB] FAIL bounce_timing step %0d: got %b required %b", k, state, (k == 13) ? 2'b01 : 2'b00);
        end
      end
    end
    total++;
    if (changes != 1) begin
      bad++;
      $display("[TB] FAIL bounce_changes: got %0d required %0d", changes, 1);
    end
  endtask

  task automatic test_clear();
    int swCount;
    holdReset(2, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) applyStimulus(k < 12, 1'b0);
    swCount = 0;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(1'b0, k < 12);
      if (sw_reset === 1'b1) swCount++;
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL clear_running_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
    total++;
    if (state !== 2'b01 || swCount != 0) begin
      bad++;
      $display("[TB] FAIL clear_in_running: got state %b pulses %0d required state 01 pulses 0", state, swCount);
    end
    for (int k = 0; k < 22; k++) applyStimulus(k < 12, 1'b0);
    total++;
    if (state !== 2'b10) begin
      bad++;
      $display("[TB] FAIL clear_setup_paused: got %b required %b", state, 2'b10);
    end
    swCount = 0;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(1'b0, k < 12);
      if (sw_reset === 1'b1) swCount++;
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL clear_paused_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
    total++;
    if (state !== 2'b00 || swCount != 1) begin
      bad++;
      $display("[TB] FAIL clear_in_paused: got state %b pulses %0d required state 00 pulses 1", state, swCount);
    end
  endtask

  task automatic test_simultaneous();
    int swCount;
    int startCount;
    holdReset(2, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) applyStimulus(k < 12, 1'b0);
    swCount = 0;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(k < 12, k < 12);
      if (sw_reset === 1'b1) swCount++;
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL both_running_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
    total++;
    if (state !== 2'b10 || swCount != 0) begin
      bad++;
      $display("[TB] FAIL both_in_running: got state %b pulses %0d required state 10 pulses 0", state, swCount);
    end
    swCount    = 0;
    startCount = 0;
    for (int k = 0; k < 22; k++) begin
      applyStimulus(k < 12, k < 12);
      if (sw_reset === 1'b1) swCount++;
      if (start === 1'b1) startCount++;
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL both_paused_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
    total++;
    if (state !== 2'b00 || swCount != 1 || startCount != 0) begin
      bad++;
      $display("[TB] FAIL both_in_paused: got state %b pulses %0d start %0d required 00 1 0", state, swCount, startCount);
    end
  endtask

  task automatic test_reset_mid_debounce();
    holdReset(2, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) applyStimulus(k < 12, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_100_Mhz);
      reset = 1'b1;
      @(posedge clk_100_Mhz);
      #1;
      total++;
      if (obsVec() !== 6'b0) begin
        bad++;
        $display("[TB] FAIL midreset_outputs: got %b required %b", obsVec(), 6'b0);
      end
    end
    mN = 0;
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1'b1, 1'b0);
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL midreset_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
      if (k == 7 || k == 8 || k == 24) begin
        total++;
        if (state !== ((k == 7) ? 2'b00 : 2'b01)) begin
          bad++;
          $display("[TB] FAIL midreset_press step %0d: got %b required %b", k, state, (k == 7) ? 2'b00 : 2'b01);
        end
      end
    end
  endtask

  task automatic test_random();
    int remS;
    int remC;
    bit s;
    bit c;
    remS = 0;
    remC = 0;
    s    = 1'b0;
    c    = 1'b0;
    holdReset(2, 1'b0, 1'b0);
    for (int k = 0; k < 1500; k++) begin
      if (remS == 0) begin
        s    = 1'($urandom_range(0, 1));
        remS = $urandom_range(1, 10);
      end
      if (remC == 0) begin
        c    = ($urandom_range(0, 3) == 0);
        remC = $urandom_range(1, 10);
      end
      remS--;
      remC--;
      applyStimulus(s, c);
      total++;
      if (obsVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL random_model step %0d: got %b required %b", k, obsVec(), expVec());
      end
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    test_reset();
    test_single_press();
    test_double_press();
    test_bounce();
    test_clear();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_button_controller.md
STOPWATCH_BUTTON_CONTROLLER -- requirements
Module: stopwatch_button_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), which sets the number of consecutive stable cycles needed to accept a button level change.
REQ-002 The block SHALL have port clk_100_Mhz, input, 1 bit: system clock. All logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset. Reset SHALL be synchronous and active-high, on clock clk_100_Mhz.
REQ-004 The block SHALL have port btn_start_stop, input, 1 bit: raw push-button, asynchronous, bouncing, active-high.
REQ-005 The block SHALL have port btn_clear, input, 1 bit: raw push-button, asynchronous, bouncing, active-high.
REQ-006 The block SHALL have port start, output, 1 bit: registered run-enable level for the downstream stopwatch counter.
REQ-007 The block SHALL have port sw_reset, output, 1 bit: registered one-cycle clear pulse for the downstream stopwatch digits.
REQ-008 The block SHALL have port state, output, 2 bits: current FSM state.
REQ-009 The block SHALL have ports running_led and paused_led, outputs, 1 bit each: status indicators.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have its own debouncer: a stable level register plus a counter of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-012 When the synchronized input equals the stable level, the debouncer counter SHALL clear to 0.
REQ-013 When the synchronized input differs from the stable level, the counter SHALL increment; on the cycle it reaches DEBOUNCE_CYCLES-1, the stable level SHALL take the input value and the counter SHALL clear.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the stable level unchanged.
REQ-015 A registered edge detector SHALL produce a one-cycle press pulse on each 0->1 transition of a stable level; a 1->0 transition SHALL produce no pulse.
REQ-016 A button held high indefinitely SHALL produce exactly one press pulse.
REQ-017 State encoding SHALL be IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10; the value 2'b11 SHALL transition to IDLE on the next cycle with sw_reset pulsed.
REQ-018 IDLE + start press SHALL go to RUNNING; RUNNING + start press SHALL go to PAUSED; PAUSED + start press SHALL go to RUNNING.
REQ-019 A clear press in IDLE or PAUSED SHALL go to IDLE and assert sw_reset for exactly one cycle.
REQ-020 A clear press in RUNNING SHALL be ignored.
REQ-021 Simultaneous start and clear presses: in RUNNING, the start press SHALL win (go to PAUSED, no sw_reset); in IDLE or PAUSED, the clear press SHALL win (go to IDLE with sw_reset pulse, start stays 0).
REQ-022 start SHALL be 1 only in RUNNING; running_led SHALL equal (state==RUNNING); paused_led SHALL equal (state==PAUSED); all SHALL be registered alongside state.
REQ-023 Latency from a clean raw edge to an output change SHALL be 2 (synchronizer) + DEBOUNCE_CYCLES (debounce) + 1 (edge pulse) + 1 (state/output register) cycles.

Reset
REQ-024 While reset=1, the following SHALL take the given values on each clock edge: state=IDLE, start=0, sw_reset=0, running_led=0, paused_led=0, synchronizers=0, stable levels=0, counters=0, edge registers=0.
REQ-025 A button already held high when reset deasserts SHALL produce one press pulse once it is debounced.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-027 Clean start press held 20 cycles from IDLE -> start=1 and state=01 exactly 8 cycles after the raw rise; no further change while held.
REQ-028 Start pressed twice with a clean release between presses -> states 00->01->10; start 0->1->0; paused_led=1 at the end.
REQ-029 Bouncing start input (1,0,1,1,0,1 per cycle, then stable 1) -> exactly one transition, occurring 8 cycles after the final stable rise.
REQ-030 Clear press in PAUSED -> state=00, sw_reset=1 for exactly 1 cycle; clear press in RUNNING -> no state change and sw_reset stays 0.
REQ-031 Both buttons rise on the same cycle: in RUNNING -> PAUSED with no sw_reset; in PAUSED -> IDLE with sw_reset pulsed.
REQ-032 Reset asserted while RUNNING with a start press mid-debounce -> all outputs 0 and state=00; after reset deasserts with the button still held, one press -> RUNNING.
